// File: rtl/eth_phy_link_monitor.sv
`default_nettype none
// ============================================================================
// Module : eth_phy_link_monitor  -- debounced link status, RX reset requests, stats
// Rev    : 1.0
// ============================================================================
module eth_phy_link_monitor #(
    parameter int STABLE_CYCLES       = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 1562500,
    parameter int RESET_PULSE_CYCLES  = 16,
    parameter int COUNT_WIDTH         = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_block_lock,
    input  logic                   rx_high_ber,
    input  logic                   rx_bad_block,
    input  logic                   rx_sequence_error,
    input  logic [6:0]             rx_error_count,
    input  logic                   force_reset,
    input  logic                   counter_clear,
    output logic                   link_up,
    output logic                   rx_reset_req,
    output logic [2:0]             link_state,
    output logic [COUNT_WIDTH-1:0] link_down_count,
    output logic [COUNT_WIDTH-1:0] reset_count,
    output logic [COUNT_WIDTH-1:0] bad_block_count,
    output logic [COUNT_WIDTH-1:0] seq_error_count,
    output logic [COUNT_WIDTH-1:0] ber_error_count
);

    localparam int TIMER_MAX_AB = (STABLE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                  STABLE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int TIMER_MAX    = (TIMER_MAX_AB > RESET_PULSE_CYCLES) ?
                                  TIMER_MAX_AB : RESET_PULSE_CYCLES;
    localparam int TIMER_W      = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

    localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] PULSE_LAST   = TIMER_W'(RESET_PULSE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ZERO   = '0;
    localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        ST_DOWN   = 3'd0,
        ST_STABLE = 3'd1,
        ST_UP     = 3'd2,
        ST_RESET  = 3'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [TIMER_W-1:0]   timer;
    logic [TIMER_W-1:0]   timer_nxt;
    logic                 good;
    logic                 inc_reset;
    logic                 inc_link_down;

    assign good = rx_block_lock && !rx_high_ber;

    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer;
        inc_reset     = 1'b0;
        inc_link_down = 1'b0;
        if (force_reset) begin
            state_nxt = ST_RESET;
            timer_nxt = TIMER_ZERO;
            inc_reset = 1'b1;
        end else begin
            case (state)
                ST_DOWN: begin
                    if (good) begin
                        state_nxt = ST_STABLE;
                        timer_nxt = TIMER_ZERO;
                    end else if (timer == TIMEOUT_LAST) begin
                        state_nxt = ST_RESET;
                        timer_nxt = TIMER_ZERO;
                        inc_reset = 1'b1;
                    end else begin
                        timer_nxt = timer + TIMER_ONE;
                    end
                end
                ST_STABLE: begin
                    if (!good) begin
                        state_nxt = ST_DOWN;
                        timer_nxt = TIMER_ZERO;
                    end else if (timer == STABLE_LAST) begin
                        state_nxt = ST_UP;
                        timer_nxt = TIMER_ZERO;
                    end else begin
                        timer_nxt = timer + TIMER_ONE;
                    end
                end
                ST_UP: begin
                    if (!good) begin
                        state_nxt = ST_DOWN;
                        timer_nxt = TIMER_ZERO;
                    end
                end
                ST_RESET: begin
                    // Status inputs are deliberately ignored while the pulse runs.
                    if (timer == PULSE_LAST) begin
                        state_nxt = ST_DOWN;
                        timer_nxt = TIMER_ZERO;
                    end else begin
                        timer_nxt = timer + TIMER_ONE;
                    end
                end
                default: begin
                    state_nxt = ST_DOWN;
                    timer_nxt = TIMER_ZERO;
                end
            endcase
        end
        if ((state == ST_UP) && (state_nxt != ST_UP)) begin
            inc_link_down = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_DOWN;
            timer        <= TIMER_ZERO;
            link_up      <= 1'b0;
            rx_reset_req <= 1'b0;
        end else begin
            state        <= state_nxt;
            timer        <= timer_nxt;
            link_up      <= (state_nxt == ST_UP);
            rx_reset_req <= (state_nxt == ST_RESET);
        end
    end

    assign link_state = state;

    // Wide sum so the clamp sees any carry out of the counter width.
    function automatic logic [COUNT_WIDTH-1:0] sat_add(
        input logic [COUNT_WIDTH-1:0] a,
        input logic [7:0]             b
    );
        logic [COUNT_WIDTH+7:0] s;
        s = {8'b0, a} + {{COUNT_WIDTH{1'b0}}, b};
        if (s > {8'b0, CNT_MAX}) begin
            return CNT_MAX;
        end
        return s[COUNT_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst || counter_clear) begin
            link_down_count <= '0;
            reset_count     <= '0;
            bad_block_count <= '0;
            seq_error_count <= '0;
            ber_error_count <= '0;
        end else begin
            link_down_count <= sat_add(link_down_count, {7'b0, inc_link_down});
            reset_count     <= sat_add(reset_count,     {7'b0, inc_reset});
            bad_block_count <= sat_add(bad_block_count, {7'b0, rx_bad_block});
            seq_error_count <= sat_add(seq_error_count, {7'b0, rx_sequence_error});
            ber_error_count <= sat_add(ber_error_count, {1'b0, rx_error_count});
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eth_phy_link_monitor.sv
`default_nettype none
// ============================================================================
// Module : tb_eth_phy_link_monitor  -- directed + random checks against a run-length model
// Rev    : 1.0
// ============================================================================
module tb_eth_phy_link_monitor;

    localparam int SC  = 8;
    localparam int TO  = 32;
    localparam int RP  = 4;
    localparam int CW  = 8;
    localparam int CMAX = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_block_lock = 1'b0;
    logic          rx_high_ber = 1'b0;
    logic          rx_bad_block = 1'b0;
    logic          rx_sequence_error = 1'b0;
    logic [6:0]    rx_error_count = 7'd0;
    logic          force_reset = 1'b0;
    logic          counter_clear = 1'b0;
    logic          link_up;
    logic          rx_reset_req;
    logic [2:0]    link_state;
    logic [CW-1:0] link_down_count;
    logic [CW-1:0] reset_count;
    logic [CW-1:0] bad_block_count;
    logic [CW-1:0] seq_error_count;
    logic [CW-1:0] ber_error_count;

    eth_phy_link_monitor #(
        .STABLE_CYCLES      (SC),
        .LOCK_TIMEOUT_CYCLES(TO),
        .RESET_PULSE_CYCLES (RP),
        .COUNT_WIDTH        (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rx_block_lock    (rx_block_lock),
        .rx_high_ber      (rx_high_ber),
        .rx_bad_block     (rx_bad_block),
        .rx_sequence_error(rx_sequence_error),
        .rx_error_count   (rx_error_count),
        .force_reset      (force_reset),
        .counter_clear    (counter_clear),
        .link_up          (link_up),
        .rx_reset_req     (rx_reset_req),
        .link_state       (link_state),
        .link_down_count  (link_down_count),
        .reset_count      (reset_count),
        .bad_block_count  (bad_block_count),
        .seq_error_count  (seq_error_count),
        .ber_error_count  (ber_error_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Model: good_run = consecutive good edges since leaving DOWN (link is up
    // once it exceeds SC), bad_run = bad edges counted in DOWN, reset_left =
    // remaining request cycles.
    int m_good_run = 0, m_bad_run = 0, m_reset_left = 0;
    int m_ldc = 0, m_rc = 0, m_bbc = 0, m_sec = 0, m_bec = 0;

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_edge();
        bit g, up;
        int d_ldc, d_rc;
        if (rst) begin
            m_good_run = 0; m_bad_run = 0; m_reset_left = 0;
            m_ldc = 0; m_rc = 0; m_bbc = 0; m_sec = 0; m_bec = 0;
            return;
        end
        g     = rx_block_lock && !rx_high_ber;
        up    = (m_reset_left == 0) && (m_good_run > SC);
        d_ldc = 0;
        d_rc  = 0;
        if (force_reset) begin
            if (up) d_ldc = 1;
            d_rc = 1;
            m_reset_left = RP;
            m_good_run = 0;
            m_bad_run = 0;
        end else if (m_reset_left > 0) begin
            m_reset_left--;
        end else if (g) begin
            m_bad_run = 0;
            if (m_good_run <= SC) m_good_run++;
        end else if (m_good_run > 0) begin
            if (up) d_ldc = 1;
            m_good_run = 0;
            m_bad_run = 0;
        end else begin
            m_bad_run++;
            if (m_bad_run == TO) begin
                d_rc = 1;
                m_reset_left = RP;
                m_bad_run = 0;
            end
        end
        if (counter_clear) begin
            m_ldc = 0; m_rc = 0; m_bbc = 0; m_sec = 0; m_bec = 0;
        end else begin
            m_ldc = sat(m_ldc + d_ldc);
            m_rc  = sat(m_rc + d_rc);
            m_bbc = sat(m_bbc + int'(rx_bad_block));
            m_sec = sat(m_sec + int'(rx_sequence_error));
            m_bec = sat(m_bec + int'(rx_error_count));
        end
    endtask

    task automatic check_all();
        int exp_state;
        exp_state = (m_reset_left > 0) ? 3 : (m_good_run > SC) ? 2 : (m_good_run > 0) ? 1 : 0;
        chk("link_state", int'(link_state), exp_state);
        chk("link_up", int'(link_up), int'(exp_state == 2));
        chk("rx_reset_req", int'(rx_reset_req), int'(exp_state == 3));
        chk("link_down_count", int'(link_down_count), m_ldc);
        chk("reset_count", int'(reset_count), m_rc);
        chk("bad_block_count", int'(bad_block_count), m_bbc);
        chk("seq_error_count", int'(seq_error_count), m_sec);
        chk("ber_error_count", int'(ber_error_count), m_bec);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input bit lock, input bit hber, input bit bb, input bit se,
                         input int ec, input bit fr, input bit cc);
        rx_block_lock     = lock;
        rx_high_ber       = hber;
        rx_bad_block      = bb;
        rx_sequence_error = se;
        rx_error_count    = 7'(ec);
        force_reset       = fr;
        counter_clear     = cc;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    initial begin
        int first_req, req_cycles, lock_p;

        do_reset();
        chk("reset_state", int'(link_state), 0);

        // Timeout: lock held low from DOWN with timer 0.
        first_req = -1;
        req_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            if (rx_reset_req) begin
                req_cycles++;
                if (first_req < 0) first_req = i;
            end
        end
        chk("timeout_first_req_edge", first_req, TO - 1);
        chk("timeout_req_cycles", req_cycles, 2 * RP);
        chk("timeout_reset_count", int'(reset_count), 2);

        // Bring-up from a fresh reset.
        do_reset();
        for (int i = 0; i <= SC; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0);
            if (i == 0)      chk("bringup_stable_after_edge0", int'(link_state), 1);
            if (i == SC - 1) chk("bringup_not_yet_up", int'(link_up), 0);
            if (i == SC)     chk("bringup_up", int'(link_up), 1);
        end
        chk("bringup_link_down_count", int'(link_down_count), 0);

        // Link loss via one high-BER cycle, then requalification.
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("loss_link_up", int'(link_up), 0);
        chk("loss_link_down_count", int'(link_down_count), 1);

        // Glitch during qualification.
        for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("glitch_back_to_down", int'(link_state), 0);
        for (int i = 0; i <= SC; i++) drive(1, 0, 0, 0, 0, 0, 0);
        chk("glitch_requalified", int'(link_up), 1);

        // force_reset while UP, then a restart at pulse cycle 2.
        drive(1, 0, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 1, 0);
        chk("force_state", int'(link_state), 3);
        chk("force_link_down_count", int'(link_down_count), 1);
        chk("force_reset_count", int'(reset_count), 1);
        req_cycles = 1;
        drive(1, 0, 0, 0, 0, 0, 0);
        if (rx_reset_req) req_cycles++;
        drive(1, 0, 0, 0, 0, 1, 0);
        if (rx_reset_req) req_cycles++;
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0);
            if (rx_reset_req) req_cycles++;
        end
        chk("force_stretched_pulse", req_cycles, 2 + RP);

        // Counters: saturation, clear priority, counting inside RESET.
        drive(1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 100, 0, 0);
        chk("ber_saturated", int'(ber_error_count), 255);
        drive(1, 0, 1, 0, 0, 0, 0);
        drive(1, 0, 1, 0, 0, 0, 1);
        chk("clear_beats_strobe", int'(bad_block_count), 0);
        drive(1, 0, 1, 1, 0, 1, 0);
        drive(1, 0, 1, 1, 3, 0, 0);
        chk("count_in_reset_bb", int'(bad_block_count), 2);
        chk("count_in_reset_ber", int'(ber_error_count), 3);

        // Randomised phases with varying lock quality.
        lock_p = 100;
        for (int i = 0; i < 4000; i++) begin
            if (i % 150 == 0) begin
                case ($urandom_range(0, 3))
                    0: lock_p = 100;
                    1: lock_p = 97;
                    2: lock_p = 50;
                    default: lock_p = 0;
                endcase
            end
            rst = ($urandom_range(0, 1999) == 0);
            drive($urandom_range(0, 99) < lock_p,
                  $urandom_range(0, 199) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0,
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 127)) : 0,
                  $urandom_range(0, 249) == 0,
                  $urandom_range(0, 299) == 0);
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
